// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: port identifiers and
// response FSM state encodings.
package ram_arbiter_pkg;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RSP  = 1'b1
  } rsp_state_t;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin grant with a last-granted pointer that only moves
// when a request is actually accepted.
module rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic last;

  // last holds the most recently granted port; reset to PORT_LS so port 0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= PORT_LS;
    end else if (|gnt) begin
      last <= gnt_id;
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (req == 2'b11) begin
        gnt = (last == PORT_LS) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
    gnt_id = gnt[1];
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto a single
// synchronous RAM, returning one response per accepted request a cycle later.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MW = 4,
  parameter int DP = 512
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_req_valid,
  output logic          m0_req_ready,
  input  logic [AW-1:0] m0_req_addr,
  input  logic          m0_req_we,
  input  logic [MW-1:0] m0_req_wem,
  input  logic [DW-1:0] m0_req_wdata,
  output logic          m0_rsp_valid,
  output logic [DW-1:0] m0_rsp_rdata,
  output logic          m0_rsp_err,

  input  logic          m1_req_valid,
  output logic          m1_req_ready,
  input  logic [AW-1:0] m1_req_addr,
  input  logic          m1_req_we,
  input  logic [MW-1:0] m1_req_wem,
  input  logic [DW-1:0] m1_req_wdata,
  output logic          m1_rsp_valid,
  output logic [DW-1:0] m1_rsp_rdata,
  output logic          m1_rsp_err,

  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [AW-1:0] LIMIT = AW'(DP * 4);

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return a < LIMIT;
  endfunction

  logic [1:0]    gnt;
  logic          gnt_id;
  logic          accept_p0;
  logic          in_range_p0;
  logic          we_p0;
  logic [AW-1:0] addr_p0;

  rsp_state_t    state, state_next;
  logic          owner_p1;
  logic          is_read_p1;
  logic          err_p1;
  logic          rsp_live;
  logic [DW-1:0] rdata_p1;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({m1_req_valid, m0_req_valid}),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // p0: request select and RAM drive
  always_comb begin
    accept_p0    = |gnt;
    m0_req_ready = gnt[0];
    m1_req_ready = gnt[1];
    addr_p0      = (gnt_id == PORT_LS) ? m1_req_addr  : m0_req_addr;
    we_p0        = (gnt_id == PORT_LS) ? m1_req_we    : m0_req_we;
    ram_wem      = (gnt_id == PORT_LS) ? m1_req_wem   : m0_req_wem;
    ram_din      = (gnt_id == PORT_LS) ? m1_req_wdata : m0_req_wdata;
    in_range_p0  = addr_ok(addr_p0);
    ram_addr     = addr_p0;
    ram_cs       = accept_p0 && in_range_p0;
    ram_we       = ram_cs && we_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept_p0)  state_next = ST_RSP;
      ST_RSP:  if (!accept_p0) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // p1: response attributes, qualified by the FSM state rather than reset
  always_ff @(posedge clk) begin
    if (accept_p0) begin
      owner_p1   <= gnt_id;
      is_read_p1 <= !we_p0;
      err_p1     <= !in_range_p0;
    end
  end

  always_comb begin
    rsp_live     = (state == ST_RSP) && !rst;
    rdata_p1     = (is_read_p1 && !err_p1) ? ram_dout : '0;
    m0_rsp_valid = rsp_live && (owner_p1 == PORT_IF);
    m1_rsp_valid = rsp_live && (owner_p1 == PORT_LS);
    m0_rsp_rdata = m0_rsp_valid ? rdata_p1 : '0;
    m1_rsp_rdata = m1_rsp_valid ? rdata_p1 : '0;
    m0_rsp_err   = m0_rsp_valid && err_p1;
    m1_rsp_err   = m1_rsp_valid && err_p1;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a behavioural RAM, a reference
// round-robin/memory model and a queue of expected responses.
module tb_ram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int DP = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    vld;
  logic [AW-1:0] addr [2];
  logic [1:0]    we;
  logic [MW-1:0] wem  [2];
  logic [DW-1:0] wdat [2];

  logic          m0_req_ready, m1_req_ready;
  logic          m0_rsp_valid, m1_rsp_valid;
  logic [DW-1:0] m0_rsp_rdata, m1_rsp_rdata;
  logic          m0_rsp_err, m1_rsp_err;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_addr;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(AW), .DW(DW), .MW(MW), .DP(DP)) dut (
    .clk          (clk),
    .rst          (rst),
    .m0_req_valid (vld[0]),
    .m0_req_ready (m0_req_ready),
    .m0_req_addr  (addr[0]),
    .m0_req_we    (we[0]),
    .m0_req_wem   (wem[0]),
    .m0_req_wdata (wdat[0]),
    .m0_rsp_valid (m0_rsp_valid),
    .m0_rsp_rdata (m0_rsp_rdata),
    .m0_rsp_err   (m0_rsp_err),
    .m1_req_valid (vld[1]),
    .m1_req_ready (m1_req_ready),
    .m1_req_addr  (addr[1]),
    .m1_req_we    (we[1]),
    .m1_req_wem   (wem[1]),
    .m1_req_wdata (wdat[1]),
    .m1_rsp_valid (m1_rsp_valid),
    .m1_rsp_rdata (m1_rsp_rdata),
    .m1_rsp_err   (m1_rsp_err),
    .ram_cs       (ram_cs),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wem      (ram_wem),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'h1000_0000 + i * 32'h0001_0203;
  endfunction

  // Behavioural synchronous RAM: read data registered, writes leave dout alone
  logic [DW-1:0] mem [DP];
  logic [DW-1:0] ref_mem [DP];
  initial begin
    ram_dout = '0;
    for (int i = 0; i < DP; i++) begin
      mem[i]     = init_word(i);
      ref_mem[i] = init_word(i);
    end
  end

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < MW; b++)
          if (ram_wem[b]) mem[ram_addr[10:2]][8*b +: 8] <= ram_din[8*b +: 8];
      end else begin
        ram_dout <= mem[ram_addr[10:2]];
      end
    end
  end

  typedef struct {
    int          cyc;
    bit          port;
    logic [31:0] rdata;
    bit          err;
  } rsp_t;

  rsp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   last = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
  endtask

  task automatic set_req(input int p, input bit v, input logic [31:0] a, input bit w,
                         input logic [3:0] m, input logic [31:0] d);
    vld[p]  = v;
    addr[p] = a;
    we[p]   = w;
    wem[p]  = m;
    wdat[p] = d;
  endtask

  task automatic idle_all();
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
  endtask

  // Checks outputs mid-cycle, advances the reference model, then steps past the next edge
  task automatic step();
    logic [1:0]  eg;
    rsp_t        e;
    bit          have;
    bit          g;
    bit          inr;
    int          idx;
    logic [31:0] a;
    e = '{cyc: 0, port: 0, rdata: 0, err: 0};
    @(negedge clk);
    if (rst) q.delete();
    have = 0;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      have = 1;
    end
    check("m0_rsp_valid", m0_rsp_valid, have && !e.port);
    check("m0_rsp_rdata", m0_rsp_rdata, (have && !e.port) ? e.rdata : 32'h0);
    check("m0_rsp_err",   m0_rsp_err,   have && !e.port && e.err);
    check("m1_rsp_valid", m1_rsp_valid, have && e.port);
    check("m1_rsp_rdata", m1_rsp_rdata, (have && e.port) ? e.rdata : 32'h0);
    check("m1_rsp_err",   m1_rsp_err,   have && e.port && e.err);

    if (rst) eg = 2'b00;
    else if (vld == 2'b11) eg = last ? 2'b01 : 2'b10;
    else eg = vld;
    check("req_ready", {m1_req_ready, m0_req_ready}, eg);

    g   = eg[1];
    a   = addr[g];
    inr = (a < DP * 4);
    check("ram_cs", ram_cs, (eg != 0) && inr);
    check("ram_we", ram_we, (eg != 0) && inr && we[g]);
    if ((eg != 0) && inr) begin
      check("ram_addr", ram_addr, a);
      check("ram_din",  ram_din,  wdat[g]);
      if (we[g]) check("ram_wem", ram_wem, wem[g]);
    end

    if (eg != 0) begin
      last = g;
      idx  = int'(a[10:2]);
      e.cyc   = cyc + 1;
      e.port  = g;
      e.err   = !inr;
      e.rdata = (inr && !we[g]) ? ref_mem[idx] : 32'h0;
      q.push_back(e);
      if (inr && we[g])
        for (int b = 0; b < 4; b++)
          if (wem[g][b]) ref_mem[idx][8*b +: 8] = wdat[g][8*b +: 8];
    end
    if (rst) last = 1'b1;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    // request held during reset must be dropped
    set_req(1, 1, 32'h30, 0, 0, 0);
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;
    idle_all();
    step();

    // both ports valid continuously: strict alternation starting with m0
    for (int k = 0; k < 6; k++) begin
      set_req(0, 1, 32'(4 * k), 0, 0, 0);
      set_req(1, 1, 32'(32'h100 + 4 * k), 0, 0, 0);
      step();
    end
    idle_all();
    step();

    // lone m0 read of the preloaded word
    set_req(0, 1, 32'h10, 0, 0, 0);
    step();
    idle_all();
    step();

    // partial write then read back
    set_req(1, 1, 32'h20, 1, 4'b0011, 32'h11223344);
    step();
    idle_all();
    set_req(0, 1, 32'h20, 0, 0, 0);
    step();
    idle_all();
    step();

    // out-of-range read
    set_req(1, 1, 32'h800, 0, 0, 0);
    step();
    idle_all();
    step();

    // read followed immediately by a write to the same word
    set_req(0, 1, 32'h40, 0, 0, 0);
    step();
    idle_all();
    set_req(1, 1, 32'h40, 1, 4'b1111, 32'hCAFEF00D);
    step();
    idle_all();
    set_req(0, 1, 32'h40, 0, 0, 0);
    step();
    idle_all();
    step();

    // mixed random traffic including out-of-range addresses
    for (int k = 0; k < 300; k++) begin
      for (int p = 0; p < 2; p++) begin
        logic [31:0] ra;
        if ($urandom_range(0, 9) == 0) ra = 32'h800 + 32'({$urandom_range(0, 255), 2'b00});
        else ra = 32'({$urandom_range(0, DP - 1), 2'b00});
        set_req(p, $urandom_range(0, 3) != 0, ra, $urandom_range(0, 2) == 0,
                4'($urandom_range(0, 15)), $urandom);
      end
      step();
    end
    idle_all();
    step();

    // reset right after an accepted read: its response must never appear
    set_req(0, 1, 32'h44, 0, 0, 0);
    step();
    idle_all();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();

    check("queue_empty", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
